// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_pkg
//  Brief    : Shared constants and state encoding for the sliced serial adder.
//  Revision : 1.0 - initial release
// ============================================================================
package add_pkg;

    // Width of one adder slice; the top processes WIDTH/SLICE_W slices.
    localparam int SLICE_W = 16;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_cla16.sv
`default_nettype none
// ============================================================================
//  Module   : cla16
//  Brief    : 16-bit two-level carry-lookahead adder (four 4-bit groups).
//  Revision : 1.0 - initial release
// ============================================================================
module cla16
    import add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [3:0]         grp_gen;
    logic [3:0]         grp_prop;
    logic [4:0]         grp_carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Group generate/propagate for each 4-bit group.
    always_comb begin
        grp_gen  = '0;
        grp_prop = '0;
        for (int j = 0; j < 4; j++) begin
            grp_gen[j]  = gen[4*j+3]
                        | (prop[4*j+3] & gen[4*j+2])
                        | (prop[4*j+3] & prop[4*j+2] & gen[4*j+1])
                        | (prop[4*j+3] & prop[4*j+2] & prop[4*j+1] & gen[4*j]);
            grp_prop[j] = &prop[4*j +: 4];
        end
    end

    // Second-level lookahead: carry into each group directly from cin.
    always_comb begin
        grp_carry    = '0;
        grp_carry[0] = cin;
        grp_carry[1] = grp_gen[0] | (grp_prop[0] & cin);
        grp_carry[2] = grp_gen[1] | (grp_prop[1] & grp_gen[0])
                     | (grp_prop[1] & grp_prop[0] & cin);
        grp_carry[3] = grp_gen[2] | (grp_prop[2] & grp_gen[1])
                     | (grp_prop[2] & grp_prop[1] & grp_gen[0])
                     | (grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
        grp_carry[4] = grp_gen[3] | (grp_prop[3] & grp_gen[2])
                     | (grp_prop[3] & grp_prop[2] & grp_gen[1])
                     | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_gen[0])
                     | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
    end

    // Sum bits within each group from the group's incoming carry.
    always_comb begin
        logic c;
        sum = '0;
        c   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            c = grp_carry[j];
            for (int i = 0; i < 4; i++) begin
                sum[4*j+i] = prop[4*j+i] ^ c;
                c          = gen[4*j+i] | (prop[4*j+i] & c);
            end
        end
    end

    assign cout = grp_carry[4];

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Multi-cycle WIDTH-bit add/subtract, one 16-bit slice per cycle
//             through a single shared CLA16, with valid/ready handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = $clog2(N) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Select the current slice of both latched operands.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                slice_a = op_a[k*SLICE_W +: SLICE_W];
                slice_b = op_b[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla16 u_cla16 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign in_ready = (state == IDLE);

    // Controller: accept, run one slice per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B and preload carry.
                        op_a  <= in_a;
                        op_b  <= in_b ^ {WIDTH{in_sub}};
                        carry <= in_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx == IDX_W'(k)) begin
                            out_sum[k*SLICE_W +: SLICE_W] <= slice_sum;
                        end
                    end
                    carry <= slice_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_cout  <= slice_cout;
                        out_ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (slice_sum[SLICE_W-1] != op_a[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, meaning operand width in bits; it SHALL be a multiple of 16 and at least 16.
REQ-002 The port list SHALL be: one clock; reset asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  controller can accept a request.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_sub  input  1  1 = compute A-B, 0 = compute A+B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 out_cout  output  1  carry out of bit WIDTH-1; no-borrow flag for subtract.
REQ-014 out_ovf  output  1  signed (two's-complement) overflow.

Function
REQ-015 States SHALL be IDLE, RUN and DONE; N = WIDTH/16 slices.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance: in IDLE with in_valid=1, the edge SHALL latch in_a, in_b XOR {WIDTH{in_sub}} and carry=in_sub, clear the slice index to 0, and move to RUN.
REQ-018 RUN datapath: each RUN cycle k (0..N-1) SHALL drive slice k (bits 16k+15:16k) of the latched operands plus the carry register through one shared 16-bit carry-lookahead adder.
REQ-019 RUN update: on each RUN edge, slice k of the result SHALL be written, carry SHALL take the slice carry-out, and the index SHALL increment.
REQ-020 On the edge completing slice N-1, the state SHALL go to DONE and out_valid SHALL assert, giving latency exactly N cycles from the acceptance edge (N=4 for the default).
REQ-021 out_cout SHALL equal the final slice carry-out.
REQ-022 out_ovf SHALL equal (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]), where B' is the inverted-if-sub operand.
REQ-023 In DONE, out_valid SHALL hold at 1, and out_sum/out_cout/out_ovf SHALL hold stable until out_ready=1.
REQ-024 On the DONE edge with out_ready=1, the state SHALL go to IDLE; minimum spacing between acceptances is N+2 cycles.
REQ-025 in_valid, in_a, in_b and in_sub SHALL be ignored outside IDLE; operands changing during RUN SHALL NOT affect the result.
REQ-026 out_sum, out_cout and out_ovf SHALL be undefined-free: they SHALL retain their last value in IDLE and RUN and update only at their RUN writes.
REQ-027 WIDTH=16 SHALL work with N=1: one RUN cycle, then DONE.
REQ-028 Carry propagation across slice boundaries SHALL be exact, including a full ripple through all slices (0xFFFF...F + 1).

Reset
REQ-029 rst_n=0 SHALL, asynchronously and at any state including mid-RUN, force: state IDLE, index 0, carry 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0.
REQ-030 After reset, in_ready SHALL be 1, and an aborted operation SHALL produce no output.

Structure
REQ-031 Shared package add_pkg SHALL hold SLICE_W=16 and the state enumeration (IDLE, RUN, DONE).
REQ-032 The block SHALL instantiate exactly one existing CLA16 sub-module as the shared slice adder; no other adder SHALL be inferred.
REQ-033 The slice index register SHALL be $clog2(N)+1 bits wide to cover N=1.

Verification
REQ-034 Add with WIDTH=64: A=0x0000_0001_FFFF_FFFF, B=0x1, sub=0 -> out_sum=0x0000_0002_0000_0000, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-035 Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> sum=0, cout=1, ovf=0.
REQ-036 Subtract: A=5, B=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; then A=7, B=5 -> sum=2, cout=1.
REQ-037 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1.
REQ-038 Backpressure and input isolation:
- hold out_ready=0 for 10 cycles in DONE -> out_valid and out_sum stable, in_ready=0;
- change in_a during RUN -> result unaffected.
REQ-039 Reset mid-RUN: assert rst_n=0 at RUN slice 2 -> all outputs 0 immediately, in_ready=1 after release, no spurious out_valid; then a new add of 3+4 -> 7.
